rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-port arbiter and pending-write scoreboard for the 15-entry register file (R0–R14; R15 supplied externally as PC+8). Two writeback requesters share the single write port (WE3/A3/WD3). Requester 0 is the single-cycle ALU path; requester 1 is the multi-cycle path (load return / multiplier). The block sits between the writeback sources and the register file, and flags read-after-write hazards on the decode read addresses A1/A2.

## Interface
Parameters:
- DW, 32, data width of WD3 and requester data
- AW, 4, register address width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESETn  in  1  reset, synchronous, active-low
- REQ0_VALID  in  1  requester 0 has a write
- REQ0_READY  out  1  requester 0 accepted this cycle
- REQ0_ADDR  in  AW  requester 0 destination register
- REQ0_DATA  in  DW  requester 0 write data
- REQ1_VALID, REQ1_READY, REQ1_ADDR, REQ1_DATA  same as above, for requester 1
- WE3  out  1  register-file write enable (registered)
- A3  out  AW  register-file write address (registered)
- WD3  out  DW  register-file write data (registered)
- RSV_VALID  in  1  multi-cycle op issued; reserve RSV_ADDR
- RSV_ADDR  in  AW  register to mark pending
- A1, A2  in  AW  decode read addresses
- HAZ1, HAZ2  out  1  read of A1/A2 would return stale data
- BUSY  out  15  pending-write bit per R0–R14
- ERR_R15  out  1  one-cycle pulse: accepted write targeted R15 and was dropped

## Operation
- Handshake: a transfer occurs when VALID && READY are both high at a rising edge. At most one READY is high per cycle. READYx depends only on the two VALIDs and the priority pointer. A requester holds VALID, ADDR and DATA stable until accepted.
- Arbitration: round-robin with a 1-bit pointer `last`.
  - Only one requester valid: it is granted.
  - Both valid: the requester not granted last is granted.
  - `last` updates only on a grant.
  - After reset, REQ0 wins the first contention.
- Write stage: on an accept, the next cycle drives WE3=1, A3=ADDR, WD3=DATA. With no accept, the next cycle drives WE3=0; A3/WD3 hold their previous values.
- R15 writes: an accept with ADDR=15 completes the handshake, but the next cycle drives WE3=0 and ERR_R15=1.
- Scoreboard (when compiled in):
  - RSV_VALID with RSV_ADDR≠15 sets BUSY[RSV_ADDR] at the next edge. A reserve of 15 is ignored. Reserving an already-busy register leaves it busy.
  - An accepted REQ1 write clears BUSY[REQ1_ADDR] at the next edge. Accepts from REQ0 never clear BUSY.
  - Set and clear of the same register in the same cycle: set wins, so the bit stays 1.
- Hazard outputs (combinational): HAZ1 = (A1≠15) && (BUSY[A1] || (WE3 && A3==A1)). HAZ2 is the same for A2. The in-flight term covers the cycle between BUSY clearing and the register file write landing.

## Timing
- Latency: accept edge → WE3 high for exactly the following cycle → register file written at the edge after that.
- Throughput: one write per cycle, sustained. Under continuous dual contention, grants strictly alternate.
- Reset (RESETn=0 at an edge):
  - WE3=0, A3=0, WD3=0, ERR_R15=0, BUSY=0, `last` set so REQ0 has priority.
  - REQ0_READY=REQ1_READY=0 while RESETn is low.
  - Reset mid-transfer discards the in-flight write and all reservations.
- HAZ1/HAZ2 are 0 during reset and for A1/A2=15.

## Configuration
- RF_WB_SCOREBOARD_EN defined: BUSY register and reserve logic are present, as described above.
- RF_WB_SCOREBOARD_EN undefined:
  - BUSY is tied to 0 and RSV_VALID/RSV_ADDR are ignored.
  - HAZ1/HAZ2 reduce to the in-flight term only.
  - Arbitration and write stage are unchanged.

## Structure
- The shared package holds:
  - the R15 address constant (4'hF);
  - the register count (15);
  - the requester-index enum (WB_ALU=0, WB_MC=1).
- One sub-module, rf_rr_arb2: 2-way round-robin grant with `last` pointer.
- Write stage, scoreboard and hazard compare live in the top module.

## Test plan
- Reset, then REQ0 only, ADDR=3, DATA=0xDEADBEEF → REQ0_READY=1 same cycle; next cycle WE3=1, A3=3, WD3=0xDEADBEEF; following cycle WE3=0.
- Both VALID for 4 cycles (REQ0 ADDR=1, REQ1 ADDR=2) → grants REQ0, REQ1, REQ0, REQ1; A3 sequence 1, 2, 1, 2.
- REQ1 ADDR=15, DATA=0x1234 → handshake completes; next cycle WE3=0, ERR_R15=1 for one cycle; BUSY unchanged.
- RSV_VALID ADDR=5, then A1=5 → BUSY[5]=1 and HAZ1=1. REQ1 write ADDR=5 accepted → BUSY[5]=0 next cycle and HAZ1 stays 1 that cycle via the in-flight term. The cycle after, HAZ1=0.
- Same cycle: RSV_VALID ADDR=7 and REQ1 accept ADDR=7 with BUSY[7]=1 → BUSY[7] remains 1.
- Reserve R4, deassert RESETn for one cycle while a write is in flight → BUSY=0, WE3=0 after the reset edge; the next contention grants REQ0.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: shared constants, requester enum and read-hazard helper
// for the register-file writeback arbiter. Rev 1.0
`default_nettype none

package rf_wb_arbiter_pkg;

  localparam logic [3:0] R15_ADDR = 4'hF;
  localparam int         NUM_REGS = 15;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MC  = 1'b1
  } wb_req_e;

  // R15 has no busy bit and is never written through this port, so it never hazards.
  function automatic logic rd_hazard(input logic [3:0]          a,
                                     input logic [NUM_REGS-1:0] busy,
                                     input logic                we,
                                     input logic [3:0]          wa);
    logic [15:0] busy_ext;
    busy_ext = {1'b0, busy};
    return (a != R15_ADDR) && (busy_ext[a] || (we && (wa == a)));
  endfunction

endpackage

`default_nettype wire

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: writeback requesters, register-file write port, reserve
// and hazard signals of the writeback arbiter. Rev 1.0
`default_nettype none

interface rf_wb_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 4
) ();

  logic                                  REQ0_VALID;
  logic                                  REQ0_READY;
  logic [AW-1:0]                         REQ0_ADDR;
  logic [DW-1:0]                         REQ0_DATA;
  logic                                  REQ1_VALID;
  logic                                  REQ1_READY;
  logic [AW-1:0]                         REQ1_ADDR;
  logic [DW-1:0]                         REQ1_DATA;
  logic                                  WE3;
  logic [AW-1:0]                         A3;
  logic [DW-1:0]                         WD3;
  logic                                  RSV_VALID;
  logic [AW-1:0]                         RSV_ADDR;
  logic [AW-1:0]                         A1;
  logic [AW-1:0]                         A2;
  logic                                  HAZ1;
  logic                                  HAZ2;
  logic [rf_wb_arbiter_pkg::NUM_REGS-1:0] BUSY;
  logic                                  ERR_R15;

  modport slave (
    input  REQ0_VALID, REQ0_ADDR, REQ0_DATA,
    input  REQ1_VALID, REQ1_ADDR, REQ1_DATA,
    input  RSV_VALID, RSV_ADDR, A1, A2,
    output REQ0_READY, REQ1_READY,
    output WE3, A3, WD3, HAZ1, HAZ2, BUSY, ERR_R15
  );

  modport master (
    output REQ0_VALID, REQ0_ADDR, REQ0_DATA,
    output REQ1_VALID, REQ1_ADDR, REQ1_DATA,
    output RSV_VALID, RSV_ADDR, A1, A2,
    input  REQ0_READY, REQ1_READY,
    input  WE3, A3, WD3, HAZ1, HAZ2, BUSY, ERR_R15
  );

endinterface

`default_nettype wire

// File: rtl/rf_rr_arb2.sv
// rf_rr_arb2: two-way round-robin grant; the requester not granted last wins
// a contention, and REQ0 wins the first one after reset. Rev 1.0
`default_nettype none

module rf_rr_arb2
  import rf_wb_arbiter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  wb_req_e last_q, last_d;

  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (rst_ni) begin
      if (req0_i && req1_i) begin
        gnt0_o = (last_q == WB_MC);
        gnt1_o = (last_q == WB_ALU);
      end else begin
        gnt0_o = req0_i;
        gnt1_o = req1_i;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt0_o) begin
      last_d = WB_ALU;
    end else if (gnt1_o) begin
      last_d = WB_MC;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q <= WB_MC;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: register-file write-port arbiter, write stage and RAW hazard
// flags. Pending-write scoreboard present when RF_WB_SCOREBOARD_EN is defined. Rev 1.0
`default_nettype none

module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic           CLK,
  input  logic           RESETn,
  rf_wb_arbiter_if.slave bus
);

  logic          gnt0;
  logic          gnt1;
  logic          acc;
  logic          acc_r15;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_data;

  logic          we3_q;
  logic          err_q;
  logic [AW-1:0] a3_q;
  logic [DW-1:0] wd3_q;
  logic [NUM_REGS-1:0] busy_q;

  rf_rr_arb2 u_arb (
    .clk_i  (CLK),
    .rst_ni (RESETn),
    .req0_i (bus.REQ0_VALID),
    .req1_i (bus.REQ1_VALID),
    .gnt0_o (gnt0),
    .gnt1_o (gnt1)
  );

  assign bus.REQ0_READY = gnt0;
  assign bus.REQ1_READY = gnt1;

  assign acc      = gnt0 | gnt1;
  assign acc_addr = gnt1 ? bus.REQ1_ADDR : bus.REQ0_ADDR;
  assign acc_data = gnt1 ? bus.REQ1_DATA : bus.REQ0_DATA;
  assign acc_r15  = acc && (acc_addr == AW'(R15_ADDR));

  // R15 writes complete the handshake but never reach the register file.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      we3_q <= 1'b0;
      err_q <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
    end else begin
      we3_q <= acc && !acc_r15;
      err_q <= acc_r15;
      if (acc && !acc_r15) begin
        a3_q  <= acc_addr;
        wd3_q <= acc_data;
      end
    end
  end

`ifdef RF_WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy_d;

  // Set is applied after clear so a same-cycle reserve keeps the bit busy.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (gnt1 && (bus.REQ1_ADDR == AW'(i))) begin
        busy_d[i] = 1'b0;
      end
      if (bus.RSV_VALID && (bus.RSV_ADDR == AW'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end
`else
  logic unused_rsv;
  assign unused_rsv = &{1'b0, bus.RSV_VALID, bus.RSV_ADDR};
  assign busy_q     = '0;
`endif

  assign bus.WE3     = we3_q;
  assign bus.A3      = a3_q;
  assign bus.WD3     = wd3_q;
  assign bus.ERR_R15 = err_q;
  assign bus.BUSY    = busy_q;

  // The in-flight term covers the cycle after BUSY clears, before WE3 lands.
  assign bus.HAZ1 = RESETn && rd_hazard(bus.A1, busy_q, we3_q, a3_q);
  assign bus.HAZ2 = RESETn && rd_hazard(bus.A2, busy_q, we3_q, a3_q);

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed vector table plus hand sequences for the
// writeback arbiter, scoreboard expectations follow RF_WB_SCOREBOARD_EN. Rev 1.0
`default_nettype none

module tb_rf_wb_arbiter;

`ifdef RF_WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic clk;
  logic rstn;

  rf_wb_arbiter_if bus ();

  rf_wb_arbiter dut (
    .CLK    (clk),
    .RESETn (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic [3:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [3:0]  a1;
    logic [31:0] d1;
    logic        r0;
    logic        r1;
    logic        we;
    logic [3:0]  a3;
    logic [31:0] wd;
    logic        err;
  } vec_t;

  vec_t vecs [14];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.REQ0_VALID = 1'b0;
    bus.REQ0_ADDR  = 4'd0;
    bus.REQ0_DATA  = 32'd0;
    bus.REQ1_VALID = 1'b0;
    bus.REQ1_ADDR  = 4'd0;
    bus.REQ1_DATA  = 32'd0;
    bus.RSV_VALID  = 1'b0;
    bus.RSV_ADDR   = 4'd0;
  endtask

  function automatic logic [14:0] sbv(input logic [14:0] v);
    return SB ? v : 15'h0;
  endfunction

  initial begin
    vecs[0]  = '{1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22, 1'b1, 1'b0, 1'b1, 4'd1, 32'h11, 1'b0};
    vecs[1]  = '{1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22, 1'b0, 1'b1, 1'b1, 4'd2, 32'h22, 1'b0};
    vecs[2]  = '{1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22, 1'b1, 1'b0, 1'b1, 4'd1, 32'h11, 1'b0};
    vecs[3]  = '{1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22, 1'b0, 1'b1, 1'b1, 4'd2, 32'h22, 1'b0};
    vecs[4]  = '{1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h0,  1'b0, 1'b0, 1'b0, 4'd2, 32'h22, 1'b0};
    vecs[5]  = '{1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0};
    vecs[6]  = '{1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h0,  1'b0, 1'b0, 1'b0, 4'd3, 32'hDEADBEEF, 1'b0};
    vecs[7]  = '{1'b0, 4'd0, 32'h0,  1'b1, 4'd15, 32'h1234, 1'b0, 1'b1, 1'b0, 4'd3, 32'hDEADBEEF, 1'b1};
    vecs[8]  = '{1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h0,  1'b0, 1'b0, 1'b0, 4'd3, 32'hDEADBEEF, 1'b0};
    vecs[9]  = '{1'b0, 4'd0, 32'h0,  1'b1, 4'd9, 32'h99, 1'b0, 1'b1, 1'b1, 4'd9, 32'h99, 1'b0};
    vecs[10] = '{1'b0, 4'd0, 32'h0,  1'b1, 4'd10, 32'hAA, 1'b0, 1'b1, 1'b1, 4'd10, 32'hAA, 1'b0};
    vecs[11] = '{1'b1, 4'd4, 32'h44, 1'b1, 4'd6, 32'h66, 1'b1, 1'b0, 1'b1, 4'd4, 32'h44, 1'b0};
    vecs[12] = '{1'b1, 4'd4, 32'h44, 1'b1, 4'd6, 32'h66, 1'b0, 1'b1, 1'b1, 4'd6, 32'h66, 1'b0};
    vecs[13] = '{1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h0,  1'b0, 1'b0, 1'b0, 4'd6, 32'h66, 1'b0};

    // Reset with both requesters pending
    idle();
    bus.A1 = 4'd15;
    bus.A2 = 4'd15;
    rstn = 1'b0;
    bus.REQ0_VALID = 1'b1;
    bus.REQ1_VALID = 1'b1;
    #1;
    chk("rst.ready0", 32'(bus.REQ0_READY), 32'd0);
    chk("rst.ready1", 32'(bus.REQ1_READY), 32'd0);
    tick();
    tick();
    chk("rst.we3",  32'(bus.WE3),     32'd0);
    chk("rst.a3",   32'(bus.A3),      32'd0);
    chk("rst.wd3",  32'(bus.WD3),     32'd0);
    chk("rst.err",  32'(bus.ERR_R15), 32'd0);
    chk("rst.busy", 32'(bus.BUSY),    32'd0);
    rstn = 1'b1;
    idle();

    // Arbitration / write-stage vector table
    for (int i = 0; i < 14; i++) begin
      bus.REQ0_VALID = vecs[i].v0;
      bus.REQ0_ADDR  = vecs[i].a0;
      bus.REQ0_DATA  = vecs[i].d0;
      bus.REQ1_VALID = vecs[i].v1;
      bus.REQ1_ADDR  = vecs[i].a1;
      bus.REQ1_DATA  = vecs[i].d1;
      #1;
      chk($sformatf("v%0d.ready0", i), 32'(bus.REQ0_READY), 32'(vecs[i].r0));
      chk($sformatf("v%0d.ready1", i), 32'(bus.REQ1_READY), 32'(vecs[i].r1));
      tick();
      chk($sformatf("v%0d.we3", i),  32'(bus.WE3),     32'(vecs[i].we));
      chk($sformatf("v%0d.a3", i),   32'(bus.A3),      32'(vecs[i].a3));
      chk($sformatf("v%0d.wd3", i),  bus.WD3,          vecs[i].wd);
      chk($sformatf("v%0d.err", i),  32'(bus.ERR_R15), 32'(vecs[i].err));
      chk($sformatf("v%0d.busy", i), 32'(bus.BUSY),    32'd0);
    end
    idle();

    // Reserve R5, then clear it with a REQ1 write; in-flight term bridges one cycle
    bus.RSV_VALID = 1'b1;
    bus.RSV_ADDR  = 4'd5;
    tick();
    idle();
    bus.A1 = 4'd5;
    bus.A2 = 4'd15;
    #1;
    chk("rsv5.busy", 32'(bus.BUSY), 32'(sbv(15'h0020)));
    chk("rsv5.haz1", 32'(bus.HAZ1), 32'(SB));
    chk("rsv5.haz2_r15", 32'(bus.HAZ2), 32'd0);
    bus.REQ1_VALID = 1'b1;
    bus.REQ1_ADDR  = 4'd5;
    bus.REQ1_DATA  = 32'h55;
    #1;
    chk("clr5.ready1", 32'(bus.REQ1_READY), 32'd1);
    tick();
    idle();
    bus.A2 = 4'd5;
    #1;
    chk("clr5.busy", 32'(bus.BUSY), 32'd0);
    chk("clr5.we3",  32'(bus.WE3),  32'd1);
    chk("clr5.a3",   32'(bus.A3),   32'd5);
    chk("clr5.haz1_inflight", 32'(bus.HAZ1), 32'd1);
    chk("clr5.haz2_inflight", 32'(bus.HAZ2), 32'd1);
    tick();
    chk("clr5.haz1_done", 32'(bus.HAZ1), 32'd0);
    chk("clr5.we3_done",  32'(bus.WE3),  32'd0);
    bus.A1 = 4'd15;
    bus.A2 = 4'd15;

    // Same-cycle set and clear of R7: set wins
    bus.RSV_VALID = 1'b1;
    bus.RSV_ADDR  = 4'd7;
    tick();
    chk("rsv7.busy", 32'(bus.BUSY), 32'(sbv(15'h0080)));
    bus.REQ1_VALID = 1'b1;
    bus.REQ1_ADDR  = 4'd7;
    bus.REQ1_DATA  = 32'h77;
    tick();
    chk("setclr7.busy", 32'(bus.BUSY), 32'(sbv(15'h0080)));
    chk("setclr7.a3",   32'(bus.A3),   32'd7);
    bus.RSV_VALID = 1'b0;
    tick();
    chk("clr7.busy", 32'(bus.BUSY), 32'd0);
    idle();

    // REQ0 writes never clear; reserve of R15 ignored
    bus.RSV_VALID = 1'b1;
    bus.RSV_ADDR  = 4'd12;
    tick();
    bus.RSV_ADDR   = 4'd15;
    bus.REQ0_VALID = 1'b1;
    bus.REQ0_ADDR  = 4'd12;
    bus.REQ0_DATA  = 32'hC0;
    tick();
    idle();
    chk("req0_no_clr.busy", 32'(bus.BUSY), 32'(sbv(15'h1000)));
    chk("req0_no_clr.a3",   32'(bus.A3),   32'd12);

    // Reserve R4 with a write in flight, then reset for one cycle
    bus.RSV_VALID  = 1'b1;
    bus.RSV_ADDR   = 4'd4;
    bus.REQ0_VALID = 1'b1;
    bus.REQ0_ADDR  = 4'd8;
    bus.REQ0_DATA  = 32'h88;
    tick();
    idle();
    chk("pre_rst.we3",  32'(bus.WE3),  32'd1);
    chk("pre_rst.busy", 32'(bus.BUSY), 32'(sbv(15'h1010)));
    rstn = 1'b0;
    bus.REQ0_VALID = 1'b1;
    bus.REQ0_ADDR  = 4'd1;
    bus.REQ0_DATA  = 32'h11;
    bus.REQ1_VALID = 1'b1;
    bus.REQ1_ADDR  = 4'd2;
    bus.REQ1_DATA  = 32'h22;
    bus.A1 = 4'd4;
    bus.A2 = 4'd8;
    #1;
    chk("mid_rst.ready0", 32'(bus.REQ0_READY), 32'd0);
    chk("mid_rst.ready1", 32'(bus.REQ1_READY), 32'd0);
    chk("mid_rst.haz1",   32'(bus.HAZ1),       32'd0);
    chk("mid_rst.haz2",   32'(bus.HAZ2),       32'd0);
    tick();
    rstn = 1'b1;
    chk("post_rst.busy", 32'(bus.BUSY), 32'd0);
    chk("post_rst.we3",  32'(bus.WE3),  32'd0);
    chk("post_rst.a3",   32'(bus.A3),   32'd0);
    #1;
    chk("post_rst.ready0", 32'(bus.REQ0_READY), 32'd1);
    chk("post_rst.ready1", 32'(bus.REQ1_READY), 32'd0);
    tick();
    chk("post_rst.a3_first", 32'(bus.A3),  32'd1);
    chk("post_rst.we3_first", 32'(bus.WE3), 32'd1);
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
